// File: rtl/cache_encoder_128_7_pkg.sv
// Shared widths and the per-group result record for the 128-line priority encoder.
package cache_encoder_128_7_pkg;
    localparam int LINES  = 128;
    localparam int IDX_W  = 7;
    localparam int GRP_W  = 16;
    localparam int NGRP   = 8;
    localparam int LIDX_W = 4;
    localparam int GSEL_W = IDX_W - LIDX_W;

    typedef struct packed {
        logic              any;
        logic [LIDX_W-1:0] idx;
        logic              multi;
    } grp_res_t;
endpackage

// File: rtl/cache_encoder_128_7_enc16.sv
// 16-bit lowest-set-bit encoder: reports any-set, lowest index and more-than-one-set.
module encoder_16_4
    import cache_encoder_128_7_pkg::*;
(
    input  logic [GRP_W-1:0] vec_i,
    output grp_res_t         res_o
);

    always_comb begin
        res_o       = '0;
        res_o.any   = |vec_i;
        // Clearing the lowest set bit leaves something only if two or more were set.
        res_o.multi = |(vec_i & (vec_i - GRP_W'(1)));
        for (int i = GRP_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                res_o.idx = LIDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cache_encoder_128_7.sv
// Two-stage valid/ready priority encoder: 128-bit match vector -> lowest index, hit, multi.
module cache_encoder_128_7
    import cache_encoder_128_7_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LINES-1:0] in_lines,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_hit,
    output logic             out_multi
);

    grp_res_t [NGRP-1:0] grp_d;
    grp_res_t [NGRP-1:0] grp_q;
    logic                s1_valid_q;
    logic                out_valid_q;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic                out_hit_q, out_hit_d;
    logic                out_multi_q, out_multi_d;
    logic [NGRP-1:0]     any_vec;
    logic                grp_multi;
    logic                s1_load, s2_load;

    for (genvar g = 0; g < NGRP; g++) begin : g_enc
        encoder_16_4 u_enc (
            .vec_i (in_lines[g*GRP_W +: GRP_W]),
            .res_o (grp_d[g])
        );
    end

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        any_vec     = '0;
        grp_multi   = 1'b0;
        out_index_d = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            any_vec[g] = grp_q[g].any;
            grp_multi  = grp_multi | grp_q[g].multi;
            if (grp_q[g].any) begin
                out_index_d = {GSEL_W'(g), grp_q[g].idx};
            end
        end
        out_hit_d   = |any_vec;
        out_multi_d = grp_multi | (|(any_vec & (any_vec - NGRP'(1))));
    end

    // S1: per-group encoder results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            grp_q      <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                grp_q <= grp_d;
            end
        end
    end

    // S2: combined result held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_hit_q   <= 1'b0;
            out_multi_q <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_index_q <= out_index_d;
                out_hit_q   <= out_hit_d;
                out_multi_q <= out_multi_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_hit   = out_hit_q;
    assign out_multi = out_multi_q;

endmodule

// File: tb/tb_cache_encoder_128_7.sv
// Directed bench for cache_encoder_128_7: latency, priority, backpressure, reset, decoder round trip.
module tb_cache_encoder_128_7;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_lines;
    logic         out_valid;
    logic         out_ready;
    logic [6:0]   out_index;
    logic         out_hit;
    logic         out_multi;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cache_encoder_128_7 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lines  (in_lines),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_hit   (out_hit),
        .out_multi (out_multi)
    );

    function automatic logic [127:0] decode(input int reg_id, input bit write_reg);
        logic [127:0] one;
        one = 128'd1;
        return write_reg ? (one << reg_id) : 128'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_lines  = '0;
        out_ready = 1'b1;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_index !== 7'd0) begin n_err++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
        n_cmp++; if ({out_hit, out_multi} !== 2'b00) begin n_err++; $display("FAIL reset_hit_multi: got %b want 00", {out_hit, out_multi}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_onehot5();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_lines  = decode(5, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL onehot5_early_valid: got %0b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL onehot5_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_index !== 7'd5) begin n_err++; $display("FAIL onehot5_index: got %0d want 5", out_index); end
        n_cmp++; if ({out_hit, out_multi} !== 2'b10) begin n_err++; $display("FAIL onehot5_hit_multi: got %b want 10", {out_hit, out_multi}); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL onehot5_no_dup: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_lines  = decode(127, 1'b1);
        tick();
        in_lines = decode(0, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_hit, out_index} !== {2'b11, 7'd127}) begin n_err++; $display("FAIL b2b_first: got v%0b h%0b i%0d want v1 h1 i127", out_valid, out_hit, out_index); end
        tick();
        n_cmp++; if ({out_valid, out_hit, out_index} !== {2'b11, 7'd0}) begin n_err++; $display("FAIL b2b_second: got v%0b h%0b i%0d want v1 h1 i0", out_valid, out_hit, out_index); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_patterns();
        logic [127:0] vecs [6];
        logic [6:0]   exp_idx [6];
        logic [1:0]   exp_hm [6];
        vecs[0] = '0;                                     exp_idx[0] = 7'd0;   exp_hm[0] = 2'b00;
        vecs[1] = decode(3, 1'b1) | decode(100, 1'b1);    exp_idx[1] = 7'd3;   exp_hm[1] = 2'b11;
        vecs[2] = decode(16, 1'b1) | decode(17, 1'b1);    exp_idx[2] = 7'd16;  exp_hm[2] = 2'b11;
        vecs[3] = '1;                                     exp_idx[3] = 7'd0;   exp_hm[3] = 2'b11;
        vecs[4] = decode(64, 1'b1);                       exp_idx[4] = 7'd64;  exp_hm[4] = 2'b10;
        vecs[5] = decode(126, 1'b1) | decode(127, 1'b1);  exp_idx[5] = 7'd126; exp_hm[5] = 2'b11;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_lines = vecs[k];
            tick();
            in_valid = 1'b0;
            tick();
            n_cmp++; if ({out_valid, out_index, out_hit, out_multi} !== {1'b1, exp_idx[k], exp_hm[k]})
                begin n_err++; $display("FAIL pattern%0d: got v%0b i%0d hm%b want v1 i%0d hm%b", k, out_valid, out_index, {out_hit, out_multi}, exp_idx[k], exp_hm[k]); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_lines  = decode(10, 1'b1);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a: got %0b want 1", in_ready); end
        tick();
        in_lines = decode(20, 1'b1);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b: got %0b want 1", in_ready); end
        tick();
        in_lines = decode(30, 1'b1);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %0b want 0", in_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if ({in_ready, out_valid, out_index, out_hit, out_multi} !== {2'b01, 7'd10, 2'b10})
                begin n_err++; $display("FAIL bp_stall%0d: got r%0b v%0b i%0d want r0 v1 i10", c, in_ready, out_valid, out_index); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_index} !== {1'b1, 7'd20}) begin n_err++; $display("FAIL bp_drain_b: got v%0b i%0d want v1 i20", out_valid, out_index); end
        tick();
        n_cmp++; if ({out_valid, out_index} !== {1'b1, 7'd30}) begin n_err++; $display("FAIL bp_drain_c: got v%0b i%0d want v1 i30", out_valid, out_index); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_lines  = decode(40, 1'b1);
        tick();
        in_lines = decode(50, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL rst_mid_full: got v%0b r%0b want v1 r0", out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_index, out_hit, out_multi} !== 10'd0) begin n_err++; $display("FAIL rst_mid_clear: got v%0b i%0d h%0b m%0b want all 0", out_valid, out_index, out_hit, out_multi); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_lines  = decode(77, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_stale: got %0b want 0", out_valid); end
        tick();
        n_cmp++; if ({out_valid, out_index, out_hit} !== {1'b1, 7'd77, 1'b1}) begin n_err++; $display("FAIL rst_mid_after: got v%0b i%0d h%0b want v1 i77 h1", out_valid, out_index, out_hit); end
        tick();
    endtask

    task automatic test_roundtrip();
        int rx;
        rx = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 132; i++) begin
            in_valid = (i < 128);
            in_lines = decode(i, i < 128);
            if (i < 128) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rt_ready%0d: got %0b want 1", i, in_ready); end
            end
            tick();
            if (out_valid === 1'b1) begin
                n_cmp++; if ({out_index, out_hit, out_multi} !== {rx[6:0], 2'b10})
                    begin n_err++; $display("FAIL rt_id%0d: got i%0d h%0b m%0b want i%0d h1 m0", rx, out_index, out_hit, out_multi, rx); end
                rx++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (rx !== 128) begin n_err++; $display("FAIL rt_count: got %0d want 128", rx); end
    endtask

    initial begin
        test_reset();
        test_onehot5();
        test_back_to_back();
        test_patterns();
        test_backpressure();
        test_reset_midstream();
        test_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_encoder_128_7.md
CACHE_ENCODER_128_7 -- requirements
Module: cache_encoder_128_7

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from package constants (LINES=128, IDX_W=7, GRP_W=16, NGRP=8).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_lines holds a vector to encode.
REQ-005 in_ready  output  1  the block accepts in_lines this cycle.
REQ-006 in_lines  input  128  wordline/match vector; bit i corresponds to line i.
REQ-007 out_valid  output  1  the out_* fields hold a result.
REQ-008 out_ready  input  1  the consumer accepts the result this cycle.
REQ-009 out_index  output  7  index of the lowest set bit of in_lines.
REQ-010 out_hit  output  1  at least one bit of in_lines was set.
REQ-011 out_multi  output  1  two or more bits of in_lines were set.

Function
REQ-012 The block SHALL be the inverse of the 7-to-128 write-wordline decoder: one-hot bit i SHALL yield out_index=i with out_hit=1 and out_multi=0.
REQ-013 Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
REQ-014 Pipeline: stage S1 SHALL register per-group results (8x {any, 4-bit local index, multi}); stage S2 SHALL register the final out_* fields.
REQ-015 Latency: with out_ready held high, a result SHALL appear on out_valid exactly 2 cycles after its input transfer.
REQ-016 Throughput: the block SHALL sustain one transfer per cycle with no bubbles while out_ready=1.
REQ-017 S2 SHALL load when !out_valid | out_ready; S1 SHALL load when !s1_valid | S2 loads; in_ready SHALL equal the S1 load condition (combinational, no dependence on in_valid).
REQ-018 Results SHALL leave in input order; no vector SHALL be dropped or duplicated under any backpressure pattern.
REQ-019 Priority: out_index SHALL be the lowest set bit: lowest group with any=1, then that group's local index; out_index = {group[2:0], local[3:0]}.
REQ-020 Zero vector: out_hit=0, out_index=0, out_multi=0.
REQ-021 out_multi SHALL be 1 if any single group has multi=1 or two or more groups have any=1.
REQ-022 While out_valid=1 and out_ready=0, all out_* fields SHALL remain stable.
REQ-023 Simultaneous S1 drain and S1 refill in the same cycle SHALL be supported (full-rate pass-through).

Reset
REQ-024 While rst_n=0: s1_valid=0, out_valid=0, out_index=0, out_hit=0, out_multi=0, and all S1 group registers=0.
REQ-025 Assertion of reset mid-operation SHALL discard all in-flight vectors immediately (asynchronous).
REQ-026 in_ready SHALL be 1 during reset and in the first cycle after reset release.

Structure
REQ-027 A shared package SHALL hold LINES, IDX_W, GRP_W and NGRP, and the S1 group-result struct {any, idx[3:0], multi}.
REQ-028 Each group SHALL be encoded by one sub-module, encoder_16_4 (16-bit vector -> any, 4-bit lowest index, multi), instantiated 8 times.

Verification
REQ-029 One-hot bit 5, out_ready=1 -> after 2 cycles: out_index=5, out_hit=1, out_multi=0.
REQ-030 One-hot bit 127, then bit 0 back-to-back -> consecutive cycles: out_index=127, then out_index=0, both with out_hit=1.
REQ-031 Zero vector -> out_hit=0, out_index=0, out_multi=0; vector with bits 3 and 100 set -> out_index=3, out_multi=1; bits 16 and 17 set -> out_index=16, out_multi=1.
REQ-032 Backpressure: 3 vectors sent while out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts, outputs stable; on out_ready=1 the results drain in order with no loss.
REQ-033 Reset mid-stream (rst_n=0 with S1 and S2 full) -> out_valid=0 and out_* fields=0 immediately; the next input after release returns its result with 2-cycle latency.
REQ-034 Round-trip: drive the 7-to-128 decoder for RegId 0..127 with WriteReg=1 into this block -> out_index equals RegId for all 128 values.
